traffic_intersection_model: RTL

- Closed-loop intersection model and protocol checker that sits on the far side of the traffic light controller interface.
- Consumes the three 2-bit light codes and drives the three sensor inputs from per-lane vehicle queues fed by arrival pulses.
- Checks the light stream for protocol violations and reports them as sticky error flags.
- Used as the standard bench partner for all light controller variants.

---
 rtl/traffic_intersection_model.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/traffic_intersection_model.sv
// ----------------------------------------------------------------------------
// traffic_intersection_model
//
// Closed-loop partner for a traffic light controller. It holds one vehicle
// queue per lane, drives the lane sensors from those queues, drains a queue
// while its light is green, and watches the light stream for protocol
// violations, which it reports as sticky error flags.
//
// Lane index used internally: 0 = ew_left, 1 = ew_str, 2 = ns.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   arrive_ew_left/_ew_str/_ns      one vehicle arrives in that lane this cycle
//   ew_left_light/ew_str_light/ns_light
//                                   2-bit light codes: 00 red, 01 yellow,
//                                   10 green, 11 illegal
//   ew_left_sensor/_str/ns_sensor   lane queue non-empty
//   q_ew_left, q_ew_str, q_ns       current queue depth (saturates at 2^QW-1)
//   dep_ew_left, dep_ew_str, dep_ns total departures, wraps mod 2^DW
//   conflict_err                    more than one lane non-red in a cycle
//   yellow_err                      yellow run length not YELLOW_CYCLES
//   skip_yellow_err                 green followed directly by red
//   green_err                       green run exceeded MAX_GREEN
//   code_err                        light code 11 seen
//   overflow_err                    arrival dropped on a full queue
// ----------------------------------------------------------------------------
module traffic_intersection_model #(
    parameter int QW            = 4,
    parameter int YELLOW_CYCLES = 2,
    parameter int MAX_GREEN     = 10,
    parameter int DW            = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          arrive_ew_left,
    input  logic          arrive_ew_str,
    input  logic          arrive_ns,
    input  logic [1:0]    ew_left_light,
    input  logic [1:0]    ew_str_light,
    input  logic [1:0]    ns_light,
    output logic          ew_left_sensor,
    output logic          ew_str_sensor,
    output logic          ns_sensor,
    output logic [QW-1:0] q_ew_left,
    output logic [QW-1:0] q_ew_str,
    output logic [QW-1:0] q_ns,
    output logic [DW-1:0] dep_ew_left,
    output logic [DW-1:0] dep_ew_str,
    output logic [DW-1:0] dep_ns,
    output logic          conflict_err,
    output logic          yellow_err,
    output logic          skip_yellow_err,
    output logic          green_err,
    output logic          code_err,
    output logic          overflow_err
);

    typedef enum logic [1:0] {
        RED    = 2'b00,
        YELLOW = 2'b01,
        GREEN  = 2'b10,
        BAD    = 2'b11
    } light_t;

    // Run counter must reach MAX_GREEN+1 (its saturation value).
    localparam int RW = $clog2(MAX_GREEN + 2);

    localparam logic [QW-1:0] Q_FULL   = '1;
    localparam logic [RW-1:0] RUN_SAT  = RW'(MAX_GREEN + 1);
    localparam logic [RW-1:0] RUN_GRN  = RW'(MAX_GREEN);
    localparam logic [RW-1:0] RUN_YEL  = RW'(YELLOW_CYCLES);
    localparam logic [RW-1:0] RUN_ONE  = RW'(1);

    // Per-lane views of the flat ports.
    logic    [2:0]    arrive;
    light_t           code  [3];
    logic    [QW-1:0] q     [3];
    logic    [DW-1:0] dep   [3];
    logic    [RW-1:0] run   [3];
    light_t           prev  [3];

    assign arrive  = {arrive_ns, arrive_ew_str, arrive_ew_left};
    assign code[0] = light_t'(ew_left_light);
    assign code[1] = light_t'(ew_str_light);
    assign code[2] = light_t'(ns_light);

    // Per-lane decode of this cycle's events.
    logic [2:0] depart;
    logic [2:0] drop;
    logic [2:0] non_red;
    logic [2:0] yel_bad;
    logic [2:0] skip_bad;
    logic [2:0] grn_bad;
    logic [2:0] code_bad;
    logic       conflict;

    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        depart   = '0;
        drop     = '0;
        non_red  = '0;
        yel_bad  = '0;
        skip_bad = '0;
        grn_bad  = '0;
        code_bad = '0;
        for (int i = 0; i < 3; i++) begin
            depart[i]   = (code[i] == GREEN) && (q[i] != '0);
            drop[i]     = arrive[i] && !depart[i] && (q[i] == Q_FULL);
            non_red[i]  = (code[i] != RED);
            code_bad[i] = (code[i] == BAD);
            // run[] describes the run of prev[], so run checks require the
            // code to be continuing that same run.
            grn_bad[i]  = (code[i] == GREEN) && (prev[i] == GREEN) &&
                          (run[i] == RUN_GRN);
            yel_bad[i]  = ((prev[i] == YELLOW) && (code[i] != YELLOW) &&
                           (run[i] != RUN_YEL)) ||
                          ((prev[i] == YELLOW) && (code[i] == YELLOW) &&
                           (run[i] == RUN_YEL));
            skip_bad[i] = (prev[i] == GREEN) && (code[i] == RED);
        end
        conflict = (non_red[0] && non_red[1]) ||
                   (non_red[0] && non_red[2]) ||
                   (non_red[1] && non_red[2]);
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // sees the pre-edge value of every other; blocking here would create
    // order-dependent simulation and mismatch synthesis.
    // NOTE: the queue, counter and history arrays are only 3 entries of
    // flops, not a RAM, so they are reset along with everything else.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                q[i]    <= '0;
                dep[i]  <= '0;
                run[i]  <= '0;
                prev[i] <= RED;
            end
            conflict_err    <= 1'b0;
            yellow_err      <= 1'b0;
            skip_yellow_err <= 1'b0;
            green_err       <= 1'b0;
            code_err        <= 1'b0;
            overflow_err    <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                // Arrival with departure leaves the queue unchanged; a full
                // queue drops a lone arrival.
                if (arrive[i] && !depart[i]) begin
                    if (q[i] != Q_FULL) begin
                        q[i] <= q[i] + 1'b1;
                    end
                end else if (depart[i] && !arrive[i]) begin
                    q[i] <= q[i] - 1'b1;
                end

                if (depart[i]) begin
                    dep[i] <= dep[i] + 1'b1;
                end

                prev[i] <= code[i];
                if (code[i] != prev[i]) begin
                    run[i] <= RUN_ONE;
                end else if (run[i] != RUN_SAT) begin
                    run[i] <= run[i] + 1'b1;
                end
            end

            if (conflict)   conflict_err    <= 1'b1;
            if (|yel_bad)   yellow_err      <= 1'b1;
            if (|skip_bad)  skip_yellow_err <= 1'b1;
            if (|grn_bad)   green_err       <= 1'b1;
            if (|code_bad)  code_err        <= 1'b1;
            if (|drop)      overflow_err    <= 1'b1;
        end
    end

    assign q_ew_left      = q[0];
    assign q_ew_str       = q[1];
    assign q_ns           = q[2];
    assign dep_ew_left    = dep[0];
    assign dep_ew_str     = dep[1];
    assign dep_ns         = dep[2];
    assign ew_left_sensor = (q[0] != '0);
    assign ew_str_sensor  = (q[1] != '0);
    assign ns_sensor      = (q[2] != '0);

endmodule
